// File: rtl/lcd1602_pkg.sv
// Shared HD44780 constants: opcodes, DDRAM map, helpers.
// Imported by the responder RTL and by its bus driver.
package lcd1602_pkg;

  localparam int DDRAM_DEPTH = 80;
  localparam int CGRAM_DEPTH = 64;

  localparam logic [6:0] L1_BASE  = 7'h00;
  localparam logic [6:0] L1_LAST  = 7'h27;
  localparam logic [6:0] L2_BASE  = 7'h40;
  localparam logic [6:0] L2_LAST  = 7'h67;
  localparam logic [6:0] ONE_LAST = 7'h4F;
  localparam logic [6:0] LINE_LEN = L1_LAST - L1_BASE + 7'd1;

  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_HOME   = 8'h02;
  localparam logic [7:0] OP_ENTRY  = 8'h04;
  localparam logic [7:0] OP_DISP   = 8'h08;
  localparam logic [7:0] OP_SHIFT  = 8'h10;
  localparam logic [7:0] OP_FUNC   = 8'h20;
  localparam logic [7:0] OP_CGADDR = 8'h40;
  localparam logic [7:0] OP_DDADDR = 8'h80;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISP,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGADDR,
    CMD_DDADDR
  } cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  // Highest set bit selects the instruction.
  function automatic cmd_e cmd_decode(input logic [7:0] d);
    cmd_e c;
    if (d >= OP_DDADDR)      c = CMD_DDADDR;
    else if (d >= OP_CGADDR) c = CMD_CGADDR;
    else if (d >= OP_FUNC)   c = CMD_FUNC;
    else if (d >= OP_SHIFT)  c = CMD_SHIFT;
    else if (d >= OP_DISP)   c = CMD_DISP;
    else if (d >= OP_ENTRY)  c = CMD_ENTRY;
    else if (d >= OP_HOME)   c = CMD_HOME;
    else if (d == OP_CLEAR)  c = CMD_CLEAR;
    else                     c = CMD_NOP;
    return c;
  endfunction

  function automatic logic addr_ok(
    input logic [6:0] a,
    input logic       two_line
  );
    logic ok;
    if (two_line)
      ok = (a <= L1_LAST) ||
           (a >= L2_BASE && a <= L2_LAST);
    else
      ok = (a <= ONE_LAST);
    return ok;
  endfunction

  // Linear cell index; line 2 follows line 1.
  function automatic logic [6:0] ddram_index(
    input logic [6:0] a,
    input logic       two_line
  );
    logic [6:0] idx;
    if (two_line && a >= L2_BASE)
      idx = a - L2_BASE + LINE_LEN;
    else
      idx = a - L1_BASE;
    return idx;
  endfunction

endpackage

// File: rtl/lcd1602_addr_step.sv
// DDRAM address counter step with line wrap.
// Ports: addr/inc/two_line in; next_addr, valid out.
module lcd1602_addr_step
  import lcd1602_pkg::*;
(
  input  logic [6:0] addr,
  input  logic       inc,
  input  logic       two_line,
  output logic [6:0] next_addr,
  output logic       valid
);

  always_comb begin
    valid     = addr_ok(addr, two_line);
    next_addr = inc ? addr + 7'd1 : addr - 7'd1;
    if (two_line) begin
      if (inc && addr == L1_LAST)
        next_addr = L2_BASE;
      else if (inc && addr == L2_LAST)
        next_addr = L1_BASE;
      else if (!inc && addr == L2_BASE)
        next_addr = L1_LAST;
      else if (!inc && addr == L1_BASE)
        next_addr = L2_LAST;
    end else begin
      if (inc && addr == ONE_LAST)
        next_addr = L1_BASE;
      else if (!inc && addr == L1_BASE)
        next_addr = ONE_LAST;
    end
  end

endmodule

// File: rtl/lcd1602_bus_responder.sv
// HD44780-style LCD bus responder: decodes bus cycles, holds DDRAM/CGRAM.
// Ports: async bus in, read-back/inspection/mode/error outputs.
module lcd1602_bus_responder
  import lcd1602_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_enable,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  input  logic [6:0] view_addr,
  output logic [7:0] view_char,
  input  logic [5:0] cg_view_addr,
  output logic [4:0] cg_view_row,
  output logic [6:0] ac,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       two_line,
  output logic       eight_bit,
  output logic       font_5x10,
  output logic       cgram_sel,
  output logic       xfer_strobe,
  output logic       err_overrun,
  output logic       err_addr,
  input  logic       err_clr
);

  logic [SYNC_STAGES-1:0] en_sync;
  bus_t                   bus_sync [SYNC_STAGES];
  logic                   en_q;
  bus_t                   bus_s;
  logic                   fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync <= '0;
      en_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        bus_sync[i] <= '0;
    end else begin
      en_sync[0]  <= lcd_enable;
      bus_sync[0] <= '{lcd_rs, lcd_rw, lcd_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        en_sync[i]  <= en_sync[i-1];
        bus_sync[i] <= bus_sync[i-1];
      end
      en_q <= en_sync[SYNC_STAGES-1];
    end
  end

  assign bus_s = bus_sync[SYNC_STAGES-1];
  assign fall  = en_q & ~en_sync[SYNC_STAGES-1];

  logic status_rd, data_rd, data_wr, cmd_wr, any_wr;
  cmd_e cmd;

  assign any_wr    = fall & ~bus_s.rw;
  assign status_rd = fall & bus_s.rw & ~bus_s.rs;
  assign data_rd   = fall & ~busy & bus_s.rw & bus_s.rs;
  assign data_wr   = any_wr & ~busy & bus_s.rs;
  assign cmd_wr    = any_wr & ~busy & ~bus_s.rs;
  assign cmd       = cmd_decode(bus_s.data);

  logic [6:0] ac_next;
  logic       ac_valid;
  logic       step_inc;

  // Cursor shift borrows the stepper with its own direction.
  assign step_inc = (cmd_wr && cmd == CMD_SHIFT) ?
                    bus_s.data[2] : entry_inc;

  lcd1602_addr_step u_step (
    .addr      (ac),
    .inc       (step_inc),
    .two_line  (two_line),
    .next_addr (ac_next),
    .valid     (ac_valid)
  );

  state_e     state, state_n;
  logic [6:0] fill_idx;
  logic       fill_last, fill_we, start_fill;

  assign fill_last  = fill_idx == 7'(DDRAM_DEPTH - 1);
  assign start_fill = cmd_wr && cmd == CMD_CLEAR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FILL;
      fill_idx <= '0;
    end else begin
      state <= state_n;
      if (state == ST_FILL && !fill_last)
        fill_idx <= fill_idx + 7'd1;
      else
        fill_idx <= '0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start_fill) state_n = ST_FILL;
      ST_FILL: if (fill_last)  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_FILL);
    fill_we = (state == ST_FILL);
  end

  logic [7:0] ddram [DDRAM_DEPTH];
  logic [4:0] cgram [CGRAM_DEPTH];
  logic [5:0] cg_addr, cg_next;
  logic [6:0] dd_idx, view_idx;
  logic       dd_we, cg_we;
  logic [7:0] rd_byte;

  assign dd_idx   = ddram_index(ac, two_line);
  assign view_idx = ddram_index(view_addr, two_line);
  assign dd_we    = data_wr & ~cgram_sel & ac_valid;
  assign cg_we    = data_wr & cgram_sel;
  assign cg_next  = entry_inc ? cg_addr + 6'd1 : cg_addr - 6'd1;
  assign rd_byte  = cgram_sel ? {3'b000, cgram[cg_addr]} :
                    ac_valid  ? ddram[dd_idx] : 8'h00;

  always_ff @(posedge clk) begin
    if (fill_we)
      ddram[fill_idx] <= FILL_CHAR;
    else if (dd_we)
      ddram[dd_idx] <= bus_s.data;
    if (cg_we)
      cgram[cg_addr] <= bus_s.data[4:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      view_char   <= '0;
      cg_view_row <= '0;
    end else begin
      view_char   <= addr_ok(view_addr, two_line) ?
                     ddram[view_idx] : 8'h00;
      cg_view_row <= cgram[cg_view_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac           <= '0;
      cg_addr      <= '0;
      cgram_sel    <= 1'b0;
      lcd_data_out <= '0;
      xfer_strobe  <= 1'b0;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_inc    <= 1'b1;
      entry_shift  <= 1'b0;
      eight_bit    <= 1'b1;
      two_line     <= 1'b0;
      font_5x10    <= 1'b0;
      err_overrun  <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      xfer_strobe <= status_rd | (fall & ~busy);

      if (status_rd)
        lcd_data_out <= {busy, ac};

      if (data_rd)
        lcd_data_out <= rd_byte;

      if (data_rd || data_wr) begin
        if (cgram_sel) cg_addr <= cg_next;
        else           ac      <= ac_next;
      end

      if (cmd_wr) begin
        unique case (cmd)
          CMD_CLEAR: begin
            ac        <= '0;
            entry_inc <= 1'b1;
            cgram_sel <= 1'b0;
          end
          CMD_HOME: ac <= '0;
          CMD_ENTRY: begin
            entry_inc   <= bus_s.data[1];
            entry_shift <= bus_s.data[0];
          end
          CMD_DISP: begin
            display_on <= bus_s.data[2];
            cursor_on  <= bus_s.data[1];
            blink_on   <= bus_s.data[0];
          end
          CMD_SHIFT:
            if (!bus_s.data[3]) ac <= ac_next;
          CMD_FUNC: begin
            eight_bit <= bus_s.data[4];
            two_line  <= bus_s.data[3];
            font_5x10 <= bus_s.data[2];
          end
          CMD_CGADDR: begin
            cg_addr   <= bus_s.data[5:0];
            cgram_sel <= 1'b1;
          end
          CMD_DDADDR: begin
            ac        <= bus_s.data[6:0];
            cgram_sel <= 1'b0;
          end
          default: ;
        endcase
      end

      if (err_clr)
        err_overrun <= 1'b0;
      else if (any_wr && busy)
        err_overrun <= 1'b1;

      if (err_clr)
        err_addr <= 1'b0;
      else if (cmd_wr && cmd == CMD_DDADDR &&
               !addr_ok(bus_s.data[6:0], two_line))
        err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// Directed bench for lcd1602_bus_responder.
// Bus cycles push expectations to a queue; strobes pop them.
module tb_lcd1602_bus_responder;
  import lcd1602_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic       lcd_enable = 1'b0;
  logic [7:0] lcd_data_in = '0;
  logic [7:0] lcd_data_out;
  logic [6:0] view_addr = '0;
  logic [7:0] view_char;
  logic [5:0] cg_view_addr = '0;
  logic [4:0] cg_view_row;
  logic [6:0] ac;
  logic       busy, display_on, cursor_on, blink_on;
  logic       entry_inc, entry_shift, two_line;
  logic       eight_bit, font_5x10, cgram_sel;
  logic       xfer_strobe, err_overrun, err_addr;
  logic       err_clr = 1'b0;

  lcd1602_bus_responder dut (
    .clk(clk), .reset(reset),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_enable(lcd_enable),
    .lcd_data_in(lcd_data_in),
    .lcd_data_out(lcd_data_out),
    .view_addr(view_addr), .view_char(view_char),
    .cg_view_addr(cg_view_addr),
    .cg_view_row(cg_view_row),
    .ac(ac), .busy(busy),
    .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc),
    .entry_shift(entry_shift), .two_line(two_line),
    .eight_bit(eight_bit), .font_5x10(font_5x10),
    .cgram_sel(cgram_sel), .xfer_strobe(xfer_strobe),
    .err_overrun(err_overrun), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   nstrobe = 0;

  always @(negedge clk)
    if (xfer_strobe === 1'b1) nstrobe++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rs_i,
                      input logic rw_i,
                      input logic [7:0] d,
                      input bit accept,
                      input logic [7:0] exp);
    bit   seen;
    exp_t e;
    if (accept) sb.push_back('{rw_i, exp});
    @(negedge clk);
    lcd_rs = rs_i;
    lcd_rw = rw_i;
    lcd_data_in = d;
    lcd_enable = 1'b1;
    repeat (4) @(negedge clk);
    lcd_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (xfer_strobe === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk($sformatf("strobe_%h", d), 32'(seen),
        32'(accept));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.rd)
        chk($sformatf("rdata_%h", d),
            32'(lcd_data_out), 32'(e.data));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    xfer(1'b0, 1'b0, d, 1'b1, 8'h00);
  endtask

  task automatic wr(input logic [7:0] d);
    xfer(1'b1, 1'b0, d, 1'b1, 8'h00);
  endtask

  task automatic vchk(input logic [6:0] a,
                      input logic [7:0] e);
    view_addr = a;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("view_%h", a),
        32'(view_char), 32'(e));
  endtask

  task automatic cgchk(input logic [5:0] a,
                       input logic [4:0] e);
    cg_view_addr = a;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("cg_%h", a),
        32'(cg_view_row), 32'(e));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic busy_len();
    int cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
      else break;
    end
    chk("busy_len", cnt, 80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_ac", 32'(ac), 32'd0);
    chk("rst_inc", 32'(entry_inc), 32'd1);
    chk("rst_8bit", 32'(eight_bit), 32'd1);
    chk("rst_2line", 32'(two_line), 32'd0);
    chk("rst_disp", 32'(display_on), 32'd0);
    chk("rst_dout", 32'(lcd_data_out), 32'd0);
    chk("rst_strobe", 32'(xfer_strobe), 32'd0);
    chk("rst_errs",
        32'({err_overrun, err_addr}), 32'd0);

    @(posedge clk);
    #1 reset = 1'b1;
    busy_len();

    cmd(8'h38);
    cmd(8'h06);
    cmd(8'h0C);
    cmd(OP_CLEAR);
    chk("eight_bit", 32'(eight_bit), 32'd1);
    chk("two_line", 32'(two_line), 32'd1);
    chk("entry_inc", 32'(entry_inc), 32'd1);
    chk("display_on", 32'(display_on), 32'd1);
    chk("cursor_on", 32'(cursor_on), 32'd0);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      vchk(7'(i), 8'h20);
      vchk(7'(8'h40 + i), 8'h20);
    end

    cmd(8'h84);
    s0 = nstrobe;
    wr("F"); wr("O"); wr("O"); wr("D");
    chk("food_strobes", nstrobe - s0, 4);
    vchk(7'h04, 8'h46);
    vchk(7'h05, 8'h4F);
    vchk(7'h06, 8'h4F);
    vchk(7'h07, 8'h44);
    chk("ac_food", 32'(ac), 32'h08);

    cmd(8'hA7);
    wr("X");
    wr("Y");
    vchk(7'h27, "X");
    vchk(7'h40, "Y");
    chk("ac_wrap_up", 32'(ac), 32'h41);
    cmd(8'h80);
    cmd(8'h04);
    wr("Z");
    vchk(7'h00, "Z");
    chk("ac_wrap_dn", 32'(ac), 32'h67);
    xfer(1'b0, 1'b1, 8'h00, 1'b1, 8'h67);
    xfer(1'b1, 1'b1, 8'h00, 1'b1, 8'h20);
    chk("ac_after_rd", 32'(ac), 32'h66);

    cmd(8'h06);
    cmd(8'h40);
    for (int i = 0; i < 8; i++) wr(8'h1F);
    chk("cgram_sel1", 32'(cgram_sel), 32'd1);
    for (int i = 0; i < 8; i++)
      cgchk(6'(i), 5'h1F);
    cmd(8'h80);
    chk("cgram_sel0", 32'(cgram_sel), 32'd0);

    cmd(8'h04);
    cmd(OP_CLEAR);
    repeat (10) @(negedge clk);
    xfer(1'b1, 1'b0, "A", 1'b0, 8'h00);
    chk("overrun_set", 32'(err_overrun), 32'd1);
    xfer(1'b0, 1'b1, 8'h00, 1'b1, 8'h80);
    chk("clr_inc", 32'(entry_inc), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("overrun_clr", 32'(err_overrun), 32'd0);
    wait_idle();
    vchk(7'h00, 8'h20);
    vchk(7'h04, 8'h20);

    cmd(8'hB0);
    chk("err_addr", 32'(err_addr), 32'd1);
    wr("Q");
    chk("ac_bad_step", 32'(ac), 32'h31);
    vchk(7'h48, 8'h20);

    cmd(OP_CLEAR);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_ac", 32'(ac), 32'd0);
    chk("rst_mid_err", 32'(err_addr), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    busy_len();

    cmd(8'hCF);
    chk("one_line_ok", 32'(err_addr), 32'd0);
    wr("W");
    chk("ac_1line_wrap", 32'(ac), 32'h00);
    vchk(7'h4F, "W");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
